// File: rtl/uart_arb_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM state encoding and a width helper.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package uart_arb_pkg;

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_WAIT = 1'b1;

  typedef enum logic {
    IDLE = ST_IDLE,
    WAIT = ST_WAIT
  } state_t;

  // Index width for n items, never below one bit so a 1-bit grant id still exists.
  function automatic int clog2_min1(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational round-robin picker with packet lock: scans upward from ptr with wrap,
// or offers only lock_id while locked. Latency: 0 cycles (pure combinational).
// Backpressure: none of its own; the caller decides when a pick is consumed.
// Ports: req (request vector), ptr (highest-priority index), lock / lock_id (restrict to owner),
//        gnt (one-hot winner), gnt_id (winner index), any_gnt (a winner exists).
module uart_rr_pick
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = clog2_min1(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  input  logic               lock,
  input  logic [ID_W-1:0]    lock_id,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    gnt_id,
  output logic               any_gnt
);

  always_comb begin
    gnt     = '0;
    gnt_id  = '0;
    any_gnt = 1'b0;
    if (lock) begin
      // Mid-packet: the owner is the only candidate, even if it has gone idle.
      for (int i = 0; i < NUM_REQ; i++) begin
        if (ID_W'(i) == lock_id && req[i]) begin
          gnt[i]  = 1'b1;
          gnt_id  = lock_id;
          any_gnt = 1'b1;
        end
      end
    end else begin
      // Step k visits index (ptr + k) mod NUM_REQ; the first valid one wins.
      for (int k = 0; k < NUM_REQ; k++) begin
        for (int i = 0; i < NUM_REQ; i++) begin
          if (!any_gnt && i == ((int'(ptr) + k) % NUM_REQ) && req[i]) begin
            gnt[i]  = 1'b1;
            gnt_id  = ID_W'(i);
            any_gnt = 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one uart_tx among NUM_REQ byte streams, round-robin, never interleaving a packet.
// Latency: accept in cycle T, uart_tx_start pulse in T+1; next accept the cycle after done.
// Backpressure: req_ready only in IDLE; held low for the whole transmitter WAIT.
// Ports: req_valid/req_data/req_last/req_ready (requester side), uart_tx_start/uart_tx_data/
//        uart_tx_done (transmitter side), grant_id (last accepted requester), busy (in WAIT),
//        timeout_err (one-cycle pulse when the watchdog abandons a stuck byte).
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int ID_W           = clog2_min1(NUM_REQ),
  parameter int TIMEOUT_CYCLES = 8192,
  parameter int TMO_W          = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [NUM_REQ*8-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 uart_tx_start,
  output logic [7:0]           uart_tx_data,
  input  logic                 uart_tx_done,
  output logic [ID_W-1:0]      grant_id,
  output logic                 busy,
  output logic                 timeout_err
);

  state_t             state;
  logic               lock;
  logic               last_r;
  logic [ID_W-1:0]    ptr;
  logic [TMO_W-1:0]   wdog;

  logic [NUM_REQ-1:0] win_gnt;
  logic [ID_W-1:0]    win_id;
  logic               win_any;
  logic [7:0]         win_byte;
  logic               win_last;
  logic [ID_W-1:0]    ptr_next;
  logic               accept;

  uart_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_pick (
    .req     (req_valid),
    .ptr     (ptr),
    .lock    (lock),
    .lock_id (grant_id),
    .gnt     (win_gnt),
    .gnt_id  (win_id),
    .any_gnt (win_any)
  );

  assign req_ready = (state == IDLE) ? win_gnt : '0;
  assign accept    = (state == IDLE) && win_any;
  assign busy      = (state == WAIT);

  // Byte and last flag of the current winner.
  always_comb begin
    win_byte = 8'h00;
    win_last = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (ID_W'(i) == win_id) begin
        win_byte = req_data[8*i +: 8];
        win_last = req_last[i];
      end
    end
  end

  // Priority moves to the requester just after the one that finished.
  assign ptr_next = (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      uart_tx_start <= 1'b0;
      uart_tx_data  <= 8'h00;
      grant_id      <= '0;
      timeout_err   <= 1'b0;
      lock          <= 1'b0;
      last_r        <= 1'b0;
      ptr           <= '0;
      wdog          <= '0;
    end else begin
      uart_tx_start <= 1'b0;
      timeout_err   <= 1'b0;
      case (state)
        IDLE: begin
          // A done pulse arriving here is stale and deliberately ignored.
          if (accept) begin
            uart_tx_data  <= win_byte;
            grant_id      <= win_id;
            last_r        <= win_last;
            lock          <= ~win_last;
            uart_tx_start <= 1'b1;
            wdog          <= '0;
            state         <= WAIT;
          end
        end
        WAIT: begin
          // Done has priority over a watchdog expiry in the same cycle.
          if (uart_tx_done) begin
            state <= IDLE;
            wdog  <= '0;
            if (last_r) begin
              lock <= 1'b0;
              ptr  <= ptr_next;
            end
          end else if (wdog == TMO_W'(TIMEOUT_CYCLES - 1)) begin
            // Abandon the whole packet so one dead transfer cannot starve everyone.
            timeout_err <= 1'b1;
            lock        <= 1'b0;
            ptr         <= ptr_next;
            wdog        <= '0;
            state       <= IDLE;
          end else begin
            wdog <= wdog + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a short watchdog and a simple transmitter stand-in.
// Latency: n/a (testbench).
// Backpressure: requester valids drop on the cycle after each valid&ready transfer.
module tb_uart_tx_arbiter;

  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;

  logic                 clk;
  logic                 rst_n;
  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ*8-1:0] req_data;
  logic [NUM_REQ-1:0]   req_last;
  logic [NUM_REQ-1:0]   req_ready;
  logic                 uart_tx_start;
  logic [7:0]           uart_tx_data;
  logic                 uart_tx_done;
  logic [ID_W-1:0]      grant_id;
  logic                 busy;
  logic                 timeout_err;

  int n_assert;
  int n_fail;
  logic [NUM_REQ-1:0] xfer;

  uart_tx_arbiter #(
    .NUM_REQ        (NUM_REQ),
    .ID_W           (ID_W),
    .TIMEOUT_CYCLES (100),
    .TMO_W          (16)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req_data      (req_data),
    .req_last      (req_last),
    .req_ready     (req_ready),
    .uart_tx_start (uart_tx_start),
    .uart_tx_data  (uart_tx_data),
    .uart_tx_done  (uart_tx_done),
    .grant_id      (grant_id),
    .busy          (busy),
    .timeout_err   (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Let combinational outputs follow freshly driven inputs.
  task automatic settle();
    #1;
  endtask

  // Advance one clock; inputs are driven and registered outputs read 3ns after the edge.
  task automatic cyc();
    xfer = req_valid & req_ready;
    @(posedge clk);
    #3;
    req_valid = req_valid & ~xfer;
  endtask

  task automatic drive(input int idx, input logic [7:0] b, input logic last);
    req_data[8*idx +: 8] = b;
    req_last[idx]        = last;
    req_valid[idx]       = 1'b1;
  endtask

  task automatic wait_start(input string tag);
    int n;
    n = 0;
    while (uart_tx_start !== 1'b1 && n < 60) begin
      cyc();
      n++;
    end
    chk({tag, "_start"}, {31'd0, uart_tx_start}, 32'd1);
  endtask

  // Stand-in transmitter: take the byte at the start pulse, "shift" ~40 cycles, pulse done.
  task automatic serve(input logic [7:0] exp, input string tag);
    wait_start(tag);
    chk({tag, "_data"}, {24'd0, uart_tx_data}, {24'd0, exp});
    repeat (38) cyc();
    uart_tx_done = 1'b1;
    cyc();
    uart_tx_done = 1'b0;
    settle();
  endtask

  initial begin
    n_assert     = 0;
    n_fail       = 0;
    rst_n        = 1'b0;
    req_valid    = '0;
    req_data     = '0;
    req_last     = '0;
    uart_tx_done = 1'b0;
    xfer         = '0;

    // Reset values
    cyc(); cyc(); settle();
    chk("rst_ready", {28'd0, req_ready}, 32'h0);
    chk("rst_start", {31'd0, uart_tx_start}, 32'h0);
    chk("rst_data", {24'd0, uart_tx_data}, 32'h0);
    chk("rst_grant", {30'd0, grant_id}, 32'h0);
    chk("rst_busy", {31'd0, busy}, 32'h0);
    chk("rst_tmo", {31'd0, timeout_err}, 32'h0);
    rst_n = 1'b1;
    cyc();

    // Single byte from req0: ready for one cycle, start one cycle later.
    drive(0, 8'hA5, 1'b1); settle();
    chk("t1_ready", {28'd0, req_ready}, 32'h1);
    cyc(); settle();
    chk("t1_start", {31'd0, uart_tx_start}, 32'h1);
    chk("t1_data", {24'd0, uart_tx_data}, 32'hA5);
    chk("t1_busy", {31'd0, busy}, 32'h1);
    chk("t1_ready_wait", {28'd0, req_ready}, 32'h0);
    cyc();
    chk("t1_start_once", {31'd0, uart_tx_start}, 32'h0);
    cyc(); cyc();
    uart_tx_done = 1'b1;
    cyc();
    uart_tx_done = 1'b0;
    chk("t1_idle", {31'd0, busy}, 32'h0);
    // Pointer now 1: req1 beats req0 (probe only, valids withdrawn before the edge).
    req_valid = 4'b0011; settle();
    chk("t1_ptr1", {28'd0, req_ready}, 32'h2);
    req_valid = '0; settle();

    // Locked 3-byte packet from req1 while req2 waits.
    drive(1, 8'h01, 1'b0); drive(2, 8'h99, 1'b1); settle();
    chk("mb_first", {28'd0, req_ready}, 32'h2);
    cyc();
    drive(1, 8'h02, 1'b0); settle();
    chk("mb_wait_ready", {28'd0, req_ready}, 32'h0);
    serve(8'h01, "mb_b1");
    chk("mb_lock2", {28'd0, req_ready}, 32'h2);
    cyc();
    drive(1, 8'h03, 1'b1);
    serve(8'h02, "mb_b2");
    chk("mb_lock3", {28'd0, req_ready}, 32'h2);
    cyc();
    serve(8'h03, "mb_b3");
    chk("mb_release", {28'd0, req_ready}, 32'h4);
    serve(8'h99, "mb_b4");

    // Single byte from req3: pointer wraps to 0, no lock.
    drive(3, 8'h33, 1'b1); settle();
    chk("s3_ready", {28'd0, req_ready}, 32'h8);
    serve(8'h33, "s3");

    // All four at once: served 0,1,2,3.
    for (int i = 0; i < 4; i++) drive(i, 8'h10 + 8'(i), 1'b1);
    settle();
    chk("rr_first", {28'd0, req_ready}, 32'h1);
    serve(8'h10, "rr0");
    serve(8'h11, "rr1");
    serve(8'h12, "rr2");
    serve(8'h13, "rr3");
    for (int i = 0; i < 4; i++) drive(i, 8'h20 + 8'(i), 1'b1);
    settle();
    chk("rr_round2", {28'd0, req_ready}, 32'h1);
    req_valid = '0; settle();

    // Watchdog: req0 locks and the transmitter never answers; req3 is pending.
    drive(0, 8'h55, 1'b0); drive(3, 8'h77, 1'b1); settle();
    chk("to_ready", {28'd0, req_ready}, 32'h1);
    cyc();
    drive(0, 8'h56, 1'b1); settle();
    chk("to_start", {31'd0, uart_tx_start}, 32'h1);
    repeat (99) cyc();
    chk("to_busy100", {31'd0, busy}, 32'h1);
    chk("to_no_err_yet", {31'd0, timeout_err}, 32'h0);
    cyc();
    chk("to_err", {31'd0, timeout_err}, 32'h1);
    chk("to_idle", {31'd0, busy}, 32'h0);
    settle();
    chk("to_next_req3", {28'd0, req_ready}, 32'h8);
    cyc();
    chk("to_err_pulse", {31'd0, timeout_err}, 32'h0);
    serve(8'h77, "to_r3");
    chk("to_wrap", {28'd0, req_ready}, 32'h1);
    serve(8'h56, "to_r0");

    // Done arrives exactly in the expiry cycle: normal completion wins.
    drive(1, 8'h66, 1'b0); drive(2, 8'h22, 1'b1); settle();
    chk("dx_ready", {28'd0, req_ready}, 32'h2);
    cyc();
    repeat (99) cyc();
    uart_tx_done = 1'b1;
    cyc();
    uart_tx_done = 1'b0;
    chk("dx_no_err", {31'd0, timeout_err}, 32'h0);
    chk("dx_idle", {31'd0, busy}, 32'h0);
    settle();
    chk("dx_lock_kept", {28'd0, req_ready}, 32'h0);
    drive(1, 8'h67, 1'b1); settle();
    chk("dx_owner", {28'd0, req_ready}, 32'h2);
    serve(8'h67, "dx_b2");
    chk("dx_release", {28'd0, req_ready}, 32'h4);
    serve(8'h22, "dx_r2");

    // Reset in the middle of a locked packet from req3 with req0 pending.
    drive(3, 8'h44, 1'b0); drive(0, 8'h88, 1'b1); settle();
    chk("mr_ready", {28'd0, req_ready}, 32'h8);
    cyc();
    chk("mr_grant", {30'd0, grant_id}, 32'h3);
    repeat (5) cyc();
    rst_n = 1'b0;
    req_valid = '0;
    settle();
    chk("mr_start", {31'd0, uart_tx_start}, 32'h0);
    chk("mr_data", {24'd0, uart_tx_data}, 32'h0);
    chk("mr_grant0", {30'd0, grant_id}, 32'h0);
    chk("mr_busy", {31'd0, busy}, 32'h0);
    chk("mr_tmo", {31'd0, timeout_err}, 32'h0);
    chk("mr_ready0", {28'd0, req_ready}, 32'h0);
    cyc();
    rst_n = 1'b1;
    drive(1, 8'h12, 1'b1); settle();
    chk("mr_unlocked", {28'd0, req_ready}, 32'h2);
    req_valid = '0;
    drive(0, 8'h88, 1'b1); settle();
    chk("mr_req0", {28'd0, req_ready}, 32'h1);
    serve(8'h88, "mr_r0");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "bench did not finish");
  end

endmodule
